ipi_buffered_smc: RTL

- Next-generation system management core for inter-processor interrupts (IPIs).
- Sits between a core's MMIO port and its IPI ring stop.
- Receive side: buffers incoming IPIs in a FIFO of configurable depth, so back-to-back IPIs are no longer lost while the core is servicing one. Overflow handling is either backpressure or counted drops.
- Send side: a registered, handshaked packet injector with unicast and broadcast addressing, generalised to NUM_CORES.

---
 rtl/ipi_buffered_smc.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ipi_buffered_smc.sv
// rtl/ipi_buffered_smc.sv - buffered IPI receive FIFO plus handshaked IPI packet injector
module ipi_buffered_smc #(
   parameter int          NUM_CORES      = 8,
   parameter int          CORE_ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
   parameter int          FIFO_DEPTH     = 4,
   parameter int          REASON_W       = 32,
   parameter logic [31:0] IPI_BASE       = 32'h0000_0000,
   parameter bit          DROP_WHEN_FULL = 1'b0
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [CORE_ID_W-1:0]            core_id,
   input  logic                            rx_valid,
   input  logic [CORE_ID_W-1:0]            rx_sender,
   input  logic [REASON_W-1:0]             rx_reason,
   output logic                            rx_ready,
   output logic                            irq_out,
   output logic [REASON_W-1:0]             irq_reason,
   output logic [CORE_ID_W-1:0]            irq_issuer,
   input  logic                            irq_ack,
   output logic [$clog2(FIFO_DEPTH):0]     pending_count,
   output logic [7:0]                      drop_count,
   input  logic                            mmio_write_en,
   input  logic [31:0]                     mmio_addr,
   input  logic [REASON_W-1:0]             mmio_data,
   output logic                            mmio_ready,
   output logic                            mmio_err,
   output logic                            tx_valid,
   input  logic                            tx_ready,
   output logic [CORE_ID_W-1:0]            tx_sender,
   output logic [NUM_CORES-1:0]            tx_dest_vector,
   output logic [REASON_W-1:0]             tx_reason
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

   // ---------------- receive FIFO ----------------
   logic [REASON_W-1:0]  reason_mem_q [FIFO_DEPTH];
   logic [CORE_ID_W-1:0] sender_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [7:0]           drop_q, drop_d;
   logic                 fifo_full, fifo_empty, pop, push, drop;

   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);
   // Pop only when something is pending, so a push into an empty FIFO survives a same-cycle ack.
   assign pop        = irq_ack && !fifo_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle (only reachable in drop mode).
   assign push       = rx_valid && rx_ready && (!fifo_full || pop);
   assign drop       = DROP_WHEN_FULL && rx_valid && fifo_full && !pop;

   assign rx_ready      = DROP_WHEN_FULL ? 1'b1 : !fifo_full;
   assign irq_out       = !fifo_empty;
   assign irq_reason    = fifo_empty ? '0 : reason_mem_q[head_q];
   assign irq_issuer    = fifo_empty ? '0 : sender_mem_q[head_q];
   assign pending_count = count_q;
   assign drop_count    = drop_q;

   // Next-state for pointers, occupancy and the saturating drop counter.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      drop_d  = drop_q;
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   // FIFO state and storage; reset discards every buffered IPI.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         drop_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            reason_mem_q[i] <= '0;
            sender_mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         drop_q  <= drop_d;
         if (push) begin
            reason_mem_q[tail_q] <= rx_reason;
            sender_mem_q[tail_q] <= rx_sender;
         end
      end
   end

   // ---------------- transmit holding register ----------------
   logic                 tx_valid_q, tx_valid_d;
   logic [NUM_CORES-1:0] dest_q, dest_d;
   logic [REASON_W-1:0]  reason_q, reason_d;
   logic [CORE_ID_W-1:0] sender_q, sender_d;
   logic                 err_q, err_d;
   logic                 wr_accept;
   logic [31:0]          slot_idx;

   assign wr_accept = mmio_write_en && !tx_valid_q;
   // Unsigned subtraction: addresses below IPI_BASE wrap to a huge index and land in the error case.
   assign slot_idx  = (mmio_addr - IPI_BASE) >> 2;

   assign mmio_ready     = !tx_valid_q;
   assign mmio_err       = err_q;
   assign tx_valid       = tx_valid_q;
   assign tx_sender      = sender_q;
   assign tx_dest_vector = dest_q;
   assign tx_reason      = reason_q;

   // Slot decode and handshake; the packet is frozen while tx_valid is high.
   always_comb begin
      tx_valid_d = tx_valid_q;
      dest_d     = dest_q;
      reason_d   = reason_q;
      sender_d   = sender_q;
      err_d      = err_q;
      if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
      if (wr_accept) begin
         if (slot_idx < 32'(NUM_CORES)) begin
            tx_valid_d = 1'b1;
            dest_d     = ONE_HOT0 << slot_idx[CORE_ID_W-1:0];
            reason_d   = mmio_data;
            sender_d   = core_id;
         end else if (slot_idx == 32'(NUM_CORES)) begin
            tx_valid_d = 1'b1;
            dest_d     = ~(ONE_HOT0 << core_id);
            reason_d   = mmio_data;
            sender_d   = core_id;
         end else begin
            err_d      = 1'b1;
         end
      end
   end

   // Transmit state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_valid_q <= 1'b0;
         dest_q     <= '0;
         reason_q   <= '0;
         sender_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         tx_valid_q <= tx_valid_d;
         dest_q     <= dest_d;
         reason_q   <= reason_d;
         sender_q   <= sender_d;
         err_q      <= err_d;
      end
   end

endmodule
